// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the data-memory arbiter and its fairness block.
//   DATA_W / ADDR_W : 32-bit data and address widths of the data-memory port.
//   STREAK_W        : width of the CPU streak counter (limits MAX_CPU_BURST to 15).
//   ARB_IDLE/CPU/DMA: encodings of the registered arb_state output.
package mips_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned STREAK_W = 4;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_CPU  = 2'd1;
    localparam logic [1:0] ARB_DMA  = 2'd2;

endpackage

// File: rtl/arb_fairness.sv
// arb_fairness: grant decision and CPU streak counter for the data-memory arbiter.
// The CPU has priority, but once it has been granted MAX_CPU_BURST times in a row
// while the DMA was waiting, the DMA gets exactly one cycle.
// Ports:
//   CLK, RST          : clock, asynchronous active-high reset
//   cpu_req, dma_req  : access requests
//   cpu_gnt, dma_gnt  : combinational grants (at most one set, none during reset)
module arb_fairness
    import mips_pkg::*;
#(
    parameter int unsigned MAX_CPU_BURST = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic cpu_req,
    input  logic dma_req,
    output logic cpu_gnt,
    output logic dma_gnt
);

    if (MAX_CPU_BURST < 1 || MAX_CPU_BURST > 15) begin : g_bad_burst
        $error("MAX_CPU_BURST must be in 1..15");
    end

    localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_CPU_BURST);

    logic [STREAK_W-1:0] streak_q, streak_d;

    // Grants are masked while RST is high so no access is acknowledged or
    // committed during reset, even between clock edges.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!RST) begin
            if (cpu_req && (!dma_req || streak_q < MAX_STREAK)) begin
                cpu_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
        end
    end

    // Counts CPU grants the DMA has had to watch; any DMA grant or an idle DMA
    // side restarts the count.
    always_comb begin
        streak_d = '0;
        if (cpu_gnt && dma_req) begin
            streak_d = (streak_q >= MAX_STREAK) ? MAX_STREAK : streak_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU MEM stage and a
// loader/DMA engine. Grant is zero-latency: ack, read data and the memory
// command all appear in the grant cycle; writes commit on the next CLK edge.
// Ports:
//   CLK, RST                                   : clock, asynchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata          : CPU request
//   cpu_rdata/cpu_ack/cpu_stall                : CPU response and pipeline stall
//   dma_req/dma_we/dma_addr/dma_wdata          : DMA request
//   dma_rdata/dma_ack                          : DMA response
//   mem_A/mem_WD/mem_WE/mem_RD                 : memory port (combinational read)
//   arb_state                                  : owner of the previous cycle
// Optional (macro DMEM_ARB_PERF_EN):
//   perf_cpu_grants/perf_dma_grants/perf_stall_cycles : wrapping 32-bit counters
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned MAX_CPU_BURST = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD,
    output logic [1:0]        arb_state
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_cpu_grants,
    output logic [31:0]       perf_dma_grants,
    output logic [31:0]       perf_stall_cycles
`endif
);

    logic       cpu_gnt, dma_gnt;
    logic [1:0] arb_state_q, arb_state_d;

    arb_fairness #(
        .MAX_CPU_BURST(MAX_CPU_BURST)
    ) u_fairness (
        .CLK    (CLK),
        .RST    (RST),
        .cpu_req(cpu_req),
        .dma_req(dma_req),
        .cpu_gnt(cpu_gnt),
        .dma_gnt(dma_gnt)
    );

    // Memory command comes only from the granted side; idle port is all zero.
    always_comb begin
        mem_A  = '0;
        mem_WD = '0;
        mem_WE = 1'b0;
        if (cpu_gnt) begin
            mem_A  = cpu_addr;
            mem_WD = cpu_wdata;
            mem_WE = cpu_we;
        end else if (dma_gnt) begin
            mem_A  = dma_addr;
            mem_WD = dma_wdata;
            mem_WE = dma_we;
        end
    end

    assign cpu_ack   = cpu_gnt;
    assign dma_ack   = dma_gnt;
    assign cpu_rdata = cpu_gnt ? mem_RD : '0;
    assign dma_rdata = dma_gnt ? mem_RD : '0;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        arb_state_d = ARB_IDLE;
        if (cpu_gnt) begin
            arb_state_d = ARB_CPU;
        end else if (dma_gnt) begin
            arb_state_d = ARB_DMA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            arb_state_q <= ARB_IDLE;
        end else begin
            arb_state_q <= arb_state_d;
        end
    end

    assign arb_state = arb_state_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_cpu_q, perf_cpu_d;
    logic [31:0] perf_dma_q, perf_dma_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_cpu_d   = perf_cpu_q + {31'd0, cpu_gnt};
        perf_dma_d   = perf_dma_q + {31'd0, dma_gnt};
        perf_stall_d = perf_stall_q + {31'd0, cpu_stall};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_cpu_q   <= '0;
            perf_dma_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_cpu_q   <= perf_cpu_d;
            perf_dma_q   <= perf_dma_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_cpu_grants   = perf_cpu_q;
    assign perf_dma_grants   = perf_dma_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic for dmem_arbiter,
// checked against a reference model that tracks "how many CPU grants has the
// waiting DMA watched" and a reference copy of memory.
module tb_dmem_arbiter;

    localparam int unsigned MAX_BURST = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_A, mem_WD, mem_RD;
    logic        cpu_ack, cpu_stall, dma_ack, mem_WE;
    logic [1:0]  arb_state;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_cpu_grants, perf_dma_grants, perf_stall_cycles;
`endif

    always #5 CLK = ~CLK;

    dmem_arbiter #(
        .MAX_CPU_BURST(MAX_BURST)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack  (cpu_ack),
        .cpu_stall(cpu_stall),
        .dma_req  (dma_req),
        .dma_we   (dma_we),
        .dma_addr (dma_addr),
        .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata),
        .dma_ack  (dma_ack),
        .mem_A    (mem_A),
        .mem_WD   (mem_WD),
        .mem_WE   (mem_WE),
        .mem_RD   (mem_RD),
        .arb_state(arb_state)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_cpu_grants  (perf_cpu_grants),
        .perf_dma_grants  (perf_dma_grants),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    // Memory behind the port: combinational read, write on the clock edge.
    logic [31:0] mem     [0:255] = '{default: 32'hDEAD_BEEF};
    logic [31:0] ref_mem [0:255] = '{default: 32'hDEAD_BEEF};

    assign mem_RD = mem[mem_A[7:0]];
    always @(posedge CLK) begin
        if (mem_WE) mem[mem_A[7:0]] <= mem_WD;
    end

    // Reference model state.
    int unsigned m_watched;   // CPU grants seen by a waiting DMA since it last ran
    logic [1:0]  m_owner;     // 0 idle, 1 cpu, 2 dma
    logic [31:0] m_cpu_cnt, m_dma_cnt, m_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_watched   = 0;
        m_owner     = 2'd0;
        m_cpu_cnt   = '0;
        m_dma_cnt   = '0;
        m_stall_cnt = '0;
    endtask

    // Who owns the port this cycle: CPU first, unless the DMA has already
    // watched MAX_BURST CPU accesses go by.
    task automatic predict(output logic cg, output logic dg);
        cg = 1'b0;
        dg = 1'b0;
        if (!RST) begin
            if (cpu_req && !(dma_req && m_watched >= MAX_BURST)) cg = 1'b1;
            else if (dma_req) dg = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic        cg, dg;
        logic [31:0] ea, ewd;
        logic        ewe;
        predict(cg, dg);
        ea  = cg ? cpu_addr  : dg ? dma_addr  : 32'd0;
        ewd = cg ? cpu_wdata : dg ? dma_wdata : 32'd0;
        ewe = cg ? cpu_we    : dg ? dma_we    : 1'b0;
        check_val({tag, ":cpu_ack"},   {31'd0, cpu_ack},   {31'd0, cg});
        check_val({tag, ":dma_ack"},   {31'd0, dma_ack},   {31'd0, dg});
        check_val({tag, ":cpu_stall"}, {31'd0, cpu_stall}, {31'd0, cpu_req && !cg});
        check_val({tag, ":mem_A"},     mem_A,  ea);
        check_val({tag, ":mem_WD"},    mem_WD, ewd);
        check_val({tag, ":mem_WE"},    {31'd0, mem_WE},    {31'd0, ewe});
        check_val({tag, ":cpu_rdata"}, cpu_rdata, cg ? ref_mem[cpu_addr[7:0]] : 32'd0);
        check_val({tag, ":dma_rdata"}, dma_rdata, dg ? ref_mem[dma_addr[7:0]] : 32'd0);
        check_val({tag, ":arb_state"}, {30'd0, arb_state}, {30'd0, m_owner});
        check_val({tag, ":streak"},    {28'd0, dut.u_fairness.streak_q}, m_watched);
`ifdef DMEM_ARB_PERF_EN
        check_val({tag, ":perf_cpu"},   perf_cpu_grants,   m_cpu_cnt);
        check_val({tag, ":perf_dma"},   perf_dma_grants,   m_dma_cnt);
        check_val({tag, ":perf_stall"}, perf_stall_cycles, m_stall_cnt);
`endif
    endtask

    // Advance one clock edge and move the model along with it.
    task automatic advance();
        logic cg, dg;
        predict(cg, dg);
        @(posedge CLK);
        if (RST) begin
            model_reset();
        end else begin
            if (cg && cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
            if (dg && dma_we) ref_mem[dma_addr[7:0]] = dma_wdata;
            m_owner = cg ? 2'd1 : dg ? 2'd2 : 2'd0;
            if (!dma_req || dg) m_watched = 0;
            else if (cg && m_watched < MAX_BURST) m_watched++;
            m_cpu_cnt   += {31'd0, cg};
            m_dma_cnt   += {31'd0, dg};
            m_stall_cnt += {31'd0, cpu_req && !cg};
        end
        #1;
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic dreq, input logic dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd);
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
    endtask

    task automatic cycle(input string tag);
        @(negedge CLK);
        check_outputs(tag);
        advance();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        #1;
        model_reset();
        advance();
        RST = 1'b0;
        #1;
    endtask

    initial begin
        logic cg, dg, cpu_hold, dma_hold;

        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        model_reset();
        @(negedge CLK);
        check_outputs("reset");
        advance();
        RST = 1'b0;

        // CPU-only write then read-back.
        drive(1, 1, 32'h10, 32'hCAFE, 0, 0, 0, 0);
        @(negedge CLK);
        check_outputs("cpu_wr");
        check_val("cpu_wr_ack", {31'd0, cpu_ack}, 32'd1);
        check_val("cpu_wr_we", {31'd0, mem_WE}, 32'd1);
        check_val("cpu_wr_stall", {31'd0, cpu_stall}, 32'd0);
        advance();
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        @(negedge CLK);
        check_outputs("cpu_rd");
        check_val("cpu_rd_data", cpu_rdata, 32'hCAFE);
        advance();

        // DMA-only write then read of 0x20.
        drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h1234);
        cycle("dma_wr");
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
        @(negedge CLK);
        check_outputs("dma_rd");
        check_val("dma_rd_ack", {31'd0, dma_ack}, 32'd1);
        check_val("dma_rd_data", dma_rdata, 32'h1234);
        check_val("dma_rd_cpu_rdata", cpu_rdata, 32'd0);
        advance();

        // Both requesting continuously: C,C,C,C,D repeating.
        do_reset();
        drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check_outputs("burst");
            check_val("burst_pattern_cpu", {31'd0, cpu_ack}, (i % 5 == 4) ? 32'd0 : 32'd1);
            check_val("burst_pattern_dma", {31'd0, dma_ack}, (i % 5 == 4) ? 32'd1 : 32'd0);
            if (i > 0) begin
                check_val("burst_owner", {30'd0, arb_state},
                          ((i - 1) % 5 == 4) ? 32'd2 : 32'd1);
            end
`ifdef DMEM_ARB_PERF_EN
            if (i == 5) check_val("perf_one_stall", perf_stall_cycles, 32'd1);
`endif
            advance();
        end

        // DMA drops at streak 3 and returns: full 4 CPU grants again.
        do_reset();
        drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        for (int i = 0; i < 3; i++) cycle("drop_pre");
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        cycle("drop_gap");
        check_val("drop_streak_clear", {28'd0, dut.u_fairness.streak_q}, 32'd0);
        drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check_outputs("drop_post");
            check_val("drop_pattern", {31'd0, dma_ack}, (i == 4) ? 32'd1 : 32'd0);
            advance();
        end

        // Reset in the middle of a granted DMA write to 0x30.
        do_reset();
        drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        for (int i = 0; i < 4; i++) cycle("rst_pre");
        drive(1, 0, 32'h10, 0, 1, 1, 32'h30, 32'h0BAD_F00D);
        @(negedge CLK);
        check_outputs("rst_dma_wr");
        check_val("rst_dma_granted", {31'd0, dma_ack}, 32'd1);
        #1;
        RST = 1'b1;
        #1;
        model_reset();
        check_val("rst_streak", {28'd0, dut.u_fairness.streak_q}, 32'd0);
        check_val("rst_state", {30'd0, arb_state}, 32'd0);
        check_val("rst_we", {31'd0, mem_WE}, 32'd0);
        check_val("rst_dma_ack", {31'd0, dma_ack}, 32'd0);
        check_val("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        check_val("rst_stall", {31'd0, cpu_stall}, 32'd1);
        advance();
        check_val("rst_no_write", mem[8'h30], 32'hDEAD_BEEF);
        RST = 1'b0;

        // Randomized traffic; a requester holds its request until acknowledged.
        cpu_hold = 1'b0;
        dma_hold = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!cpu_hold) begin
                cpu_req   = ($urandom_range(0, 3) != 0);
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = $urandom_range(0, 255);
                cpu_wdata = $urandom;
            end
            if (!dma_hold) begin
                dma_req   = ($urandom_range(0, 3) != 0);
                dma_we    = $urandom_range(0, 1) == 1;
                dma_addr  = $urandom_range(0, 255);
                dma_wdata = $urandom;
            end
            @(negedge CLK);
            check_outputs("rand");
            predict(cg, dg);
            cpu_hold = cpu_req && !cg;
            dma_hold = dma_req && !dg;
            advance();
        end
        for (int a = 0; a < 256; a++) begin
            check_val("rand_mem", mem[a], ref_mem[a]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
